// File: rtl/riscv_pkg.sv
// Shared definitions for the register-file write-port controller.
// REGFILE_SIZE is the number of architectural registers per hardware thread.
package riscv_pkg;

  localparam int          REGFILE_SIZE        = 32;
  localparam int          REG_ADDR_W          = 5;
  localparam logic [4:0]  SP_REG_IDX          = 5'd2;
  localparam logic [31:0] DEFAULT_SP_BASE     = 32'h0000_1000;
  localparam logic [31:0] DEFAULT_STACK_BYTES = 32'h0000_0400;

  typedef enum logic [1:0] {
    RF_INIT  = 2'd0,
    RF_RUN   = 2'd1,
    RF_CLEAR = 2'd2
  } rf_ctrl_state_t;

endpackage

// File: rtl/regfile_init_ctrl.sv
// Write-port sequencer / arbiter in front of the multithreaded BRAM register
// file. After reset it sweeps every (thread, register) entry to a known value
// and holds o_init_done low until that is finished. At run time it forwards
// writeback writes (dropping x0) and services per-thread clear requests in
// write-port slots that writeback leaves idle.
//
// Optional build macro: REGFILE_SP_INIT_EN -- when defined, the sweep and the
// per-thread clear write x2 of thread t with SP_BASE - t*STACK_BYTES instead
// of zero.
//
// Clear handshake: i_clr_req is a level held with a stable i_clr_thread until
// o_clr_ack pulses for one cycle. The request is not sampled in the ack cycle
// itself; if it is still high in the cycle after the ack, a new clear starts.
// Requests raised during the post-reset sweep stay pending until it completes.
module regfile_init_ctrl
  import riscv_pkg::*;
#(
  parameter int                 DWIDTH      = 32,
  parameter int                 NUM_THREADS = 4,
  parameter logic [DWIDTH-1:0]  SP_BASE     = DWIDTH'(DEFAULT_SP_BASE),
  parameter logic [DWIDTH-1:0]  STACK_BYTES = DWIDTH'(DEFAULT_STACK_BYTES)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           i_wb_wr_en,
  input  logic [$clog2(NUM_THREADS)-1:0] i_wb_thread,
  input  logic [4:0]                     i_wb_addr,
  input  logic [DWIDTH-1:0]              i_wb_data,
  input  logic                           i_clr_req,
  input  logic [$clog2(NUM_THREADS)-1:0] i_clr_thread,
  output logic                           o_clr_ack,
  output logic                           o_rf_wr_en,
  output logic [$clog2(NUM_THREADS)-1:0] o_rf_thread,
  output logic [4:0]                     o_rf_addr,
  output logic [DWIDTH-1:0]              o_rf_data,
  output logic                           o_init_done,
  output logic                           o_busy,
  output rf_ctrl_state_t                 o_dbg_state
);

  localparam int             TW       = $clog2(NUM_THREADS);
  localparam int             CW       = TW + REG_ADDR_W;
  localparam int             RF_SIZE  = NUM_THREADS * REGFILE_SIZE;
  localparam logic [CW-1:0]  CNT_LAST = CW'(RF_SIZE - 1);
  localparam logic [4:0]     REG_LAST = 5'(REGFILE_SIZE - 1);

  rf_ctrl_state_t    state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [TW-1:0]     clr_thread, clr_thread_nxt;

  logic              wr_en_nxt;
  logic [TW-1:0]     thread_nxt;
  logic [4:0]        addr_nxt;
  logic [DWIDTH-1:0] data_nxt;
  logic              done_nxt;
  logic              ack_nxt;
  logic              busy_nxt;

  logic              wb_fwd;
  logic [TW-1:0]     sweep_thread;
  logic [4:0]        sweep_addr;
  logic [DWIDTH-1:0] sweep_wdata;

  // Entry targeted by the sweep: the whole file in INIT, one thread in CLEAR.
  assign sweep_thread = (state == RF_INIT) ? cnt[CW-1:REG_ADDR_W] : clr_thread;
  assign sweep_addr   = cnt[REG_ADDR_W-1:0];
  // A writeback write only occupies the port when it targets a real register.
  assign wb_fwd       = i_wb_wr_en && (i_wb_addr != 5'd0);

`ifdef REGFILE_SP_INIT_EN
  assign sweep_wdata = (sweep_addr == SP_REG_IDX)
                     ? SP_BASE - (DWIDTH'(sweep_thread) * STACK_BYTES)
                     : '0;
`else
  logic unused_sp_cfg;
  assign sweep_wdata   = '0;
  assign unused_sp_cfg = ^{SP_BASE, STACK_BYTES, SP_REG_IDX};
`endif

  assign o_dbg_state = state;

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RF_INIT;
      cnt         <= '0;
      clr_thread  <= '0;
      o_rf_wr_en  <= 1'b0;
      o_rf_thread <= '0;
      o_rf_addr   <= '0;
      o_rf_data   <= '0;
      o_init_done <= 1'b0;
      o_clr_ack   <= 1'b0;
      o_busy      <= 1'b1;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      clr_thread  <= clr_thread_nxt;
      o_rf_wr_en  <= wr_en_nxt;
      o_rf_thread <= thread_nxt;
      o_rf_addr   <= addr_nxt;
      o_rf_data   <= data_nxt;
      o_init_done <= done_nxt;
      o_clr_ack   <= ack_nxt;
      o_busy      <= busy_nxt;
    end
  end

  // Next state and next output values: sweep, forward or clear.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    clr_thread_nxt = clr_thread;
    wr_en_nxt      = 1'b0;
    thread_nxt     = o_rf_thread;
    addr_nxt       = o_rf_addr;
    data_nxt       = o_rf_data;
    done_nxt       = o_init_done;
    ack_nxt        = 1'b0;
    busy_nxt       = o_busy;

    case (state)
      RF_INIT: begin
        wr_en_nxt  = 1'b1;
        thread_nxt = sweep_thread;
        addr_nxt   = sweep_addr;
        data_nxt   = sweep_wdata;
        busy_nxt   = 1'b1;
        if (cnt == CNT_LAST) begin
          state_nxt = RF_RUN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      RF_RUN: begin
        // First RUN cycle also raises init_done and drops busy.
        done_nxt   = 1'b1;
        busy_nxt   = 1'b0;
        wr_en_nxt  = wb_fwd;
        thread_nxt = i_wb_thread;
        addr_nxt   = i_wb_addr;
        data_nxt   = i_wb_data;
        if (i_clr_req && !o_clr_ack) begin
          state_nxt      = RF_CLEAR;
          cnt_nxt        = '0;
          clr_thread_nxt = i_clr_thread;
          busy_nxt       = 1'b1;
        end
      end

      RF_CLEAR: begin
        if (wb_fwd) begin
          // Writeback wins the port; the clear position holds.
          wr_en_nxt  = 1'b1;
          thread_nxt = i_wb_thread;
          addr_nxt   = i_wb_addr;
          data_nxt   = i_wb_data;
        end else begin
          wr_en_nxt  = 1'b1;
          thread_nxt = sweep_thread;
          addr_nxt   = sweep_addr;
          data_nxt   = sweep_wdata;
          if (sweep_addr == REG_LAST) begin
            state_nxt = RF_RUN;
            ack_nxt   = 1'b1;
            busy_nxt  = 1'b0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end

      default: begin
        state_nxt = RF_INIT;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_init_ctrl.sv
// Bench for regfile_init_ctrl (NUM_THREADS=4, DWIDTH=32). A queue-based
// reference model predicts the registered outputs every cycle; directed
// sections pin sweep order, x0 dropping, clear latency and mid-sweep reset
// with literal values. Build with +define+REGFILE_SP_INIT_EN to cover x2 init.
module tb_regfile_init_ctrl;
  import riscv_pkg::*;

  localparam int          DW  = 32;
  localparam int          NT  = 4;
  localparam int          TW  = 2;
  localparam int          RF  = NT * 32;
  localparam logic [31:0] SPB = 32'h0000_1000;
  localparam logic [31:0] STK = 32'h0000_0400;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          wb_wr_en = 1'b0;
  logic [TW-1:0] wb_thread = '0;
  logic [4:0]    wb_addr = '0;
  logic [DW-1:0] wb_data = '0;
  logic          clr_req = 1'b0;
  logic [TW-1:0] clr_thread = '0;

  logic           o_clr_ack, o_rf_wr_en, o_init_done, o_busy;
  logic [TW-1:0]  o_rf_thread;
  logic [4:0]     o_rf_addr;
  logic [DW-1:0]  o_rf_data;
  rf_ctrl_state_t dbg_state;

  regfile_init_ctrl #(
    .DWIDTH(DW), .NUM_THREADS(NT), .SP_BASE(SPB), .STACK_BYTES(STK)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .i_wb_wr_en(wb_wr_en), .i_wb_thread(wb_thread), .i_wb_addr(wb_addr),
    .i_wb_data(wb_data), .i_clr_req(clr_req), .i_clr_thread(clr_thread),
    .o_clr_ack(o_clr_ack), .o_rf_wr_en(o_rf_wr_en), .o_rf_thread(o_rf_thread),
    .o_rf_addr(o_rf_addr), .o_rf_data(o_rf_data), .o_init_done(o_init_done),
    .o_busy(o_busy), .o_dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] sp_lit [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Value the sweep/clear writes into (thread, register).
  function automatic logic [31:0] fill_value(input int thr, input int addr);
    logic [31:0] v;
    v = 32'h0;
`ifdef REGFILE_SP_INIT_EN
    if (addr == 2) v = SPB - (32'(thr) * STK);
`endif
    return v;
  endfunction

  // ---------------- reference model ----------------
  int          init_idx;
  int          clear_q[$];
  int          m_clr_thr;
  logic        exp_wr, exp_done, exp_ack, exp_busy;
  logic [TW-1:0] exp_thr;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;

  task automatic model_reset();
    init_idx = 0;
    clear_q.delete();
    m_clr_thr = 0;
    exp_wr = 1'b0; exp_thr = '0; exp_addr = '0; exp_data = '0;
    exp_done = 1'b0; exp_ack = 1'b0; exp_busy = 1'b1;
  endtask

  task automatic model_step();
    logic prev_ack;
    int   a;
    prev_ack = exp_ack;
    exp_ack  = 1'b0;
    exp_wr   = 1'b0;
    if (init_idx < RF) begin
      exp_wr   = 1'b1;
      exp_thr  = TW'(init_idx / 32);
      exp_addr = 5'(init_idx % 32);
      exp_data = fill_value(init_idx / 32, init_idx % 32);
      exp_busy = 1'b1;
      init_idx++;
    end else if (clear_q.size() == 0) begin
      exp_done = 1'b1;
      exp_busy = 1'b0;
      exp_wr   = wb_wr_en && (wb_addr != 0);
      exp_thr  = wb_thread;
      exp_addr = wb_addr;
      exp_data = wb_data;
      if (clr_req && !prev_ack) begin
        m_clr_thr = int'(clr_thread);
        for (int r = 0; r < 32; r++) clear_q.push_back(r);
        exp_busy = 1'b1;
      end
    end else begin
      exp_wr = 1'b1;
      if (wb_wr_en && (wb_addr != 0)) begin
        exp_thr  = wb_thread;
        exp_addr = wb_addr;
        exp_data = wb_data;
      end else begin
        a        = clear_q.pop_front();
        exp_thr  = TW'(m_clr_thr);
        exp_addr = 5'(a);
        exp_data = fill_value(m_clr_thr, a);
        if (clear_q.size() == 0) begin
          exp_ack  = 1'b1;
          exp_busy = 1'b0;
        end
      end
    end
  endtask

  // ---------------- compare process (every cycle, incl. reset) ----------------
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else          model_step();
      #1;
      chk("m_wr_en",  o_rf_wr_en,  exp_wr);
      chk("m_thread", o_rf_thread, exp_thr);
      chk("m_addr",   o_rf_addr,   exp_addr);
      chk("m_data",   o_rf_data,   exp_data);
      chk("m_done",   o_init_done, exp_done);
      chk("m_ack",    o_clr_ack,   exp_ack);
      chk("m_busy",   o_busy,      exp_busy);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    wb_wr_en = 1'b0; wb_thread = '0; wb_addr = '0; wb_data = '0;
  endtask

  // Called right after reset release at a negedge: literal sweep order check.
  task automatic check_sweep(input string tag);
    for (int i = 0; i < RF; i++) begin
      @(posedge clk); #2;
      chk({tag, "_wr"},  o_rf_wr_en, 1);
      chk({tag, "_idx"}, {o_rf_thread, o_rf_addr}, i);
      if (i % 32 == 2) chk({tag, "_x2"}, o_rf_data, sp_lit[i / 32]);
      else             chk({tag, "_zero"}, o_rf_data, 0);
      chk({tag, "_notdone"}, o_init_done, 0);
    end
    @(posedge clk); #2;
    chk({tag, "_done_rise"}, o_init_done, 1);
  endtask

  // Wait (bounded) for the ack, keep the request through the ack cycle, drop after.
  task automatic finish_clear(input string tag);
    int waited;
    waited = 0;
    while (!o_clr_ack && waited < 100) begin
      @(posedge clk); #2;
      waited++;
    end
    chk({tag, "_ack_seen"}, o_clr_ack, 1);
    @(negedge clk);
    @(posedge clk); #2;
    chk({tag, "_no_restart"}, o_busy, 0);
    @(negedge clk);
    clr_req = 1'b0;
  endtask

  task automatic random_wb();
    wb_wr_en  = ($urandom_range(0, 2) != 0);
    wb_thread = TW'($urandom_range(0, NT - 1));
    wb_addr   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    wb_data   = $urandom;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   cyc, fwd, clrw, clr_next;
    logic got_ack, drop_next;
    logic [31:0] stall_mask;
    int   pick;

`ifdef REGFILE_SP_INIT_EN
    sp_lit[0] = 32'h0000_1000; sp_lit[1] = 32'h0000_0C00;
    sp_lit[2] = 32'h0000_0800; sp_lit[3] = 32'h0000_0400;
`else
    sp_lit[0] = 32'h0; sp_lit[1] = 32'h0; sp_lit[2] = 32'h0; sp_lit[3] = 32'h0;
`endif

    // Reset state.
    drive_idle();
    repeat (3) @(negedge clk);
    #2;
    chk("rst_wr_en", o_rf_wr_en, 0);
    chk("rst_done",  o_init_done, 0);
    chk("rst_busy",  o_busy, 1);
    @(negedge clk);
    reset_n = 1'b1;

    // Sweep with idle inputs.
    check_sweep("sweep0");
    chk("sweep0_post_wr", o_rf_wr_en, 0);
    chk("sweep0_post_busy", o_busy, 0);

    // Sweep with a writeback write held throughout: never forwarded in INIT.
    @(negedge clk);
    reset_n = 1'b0;
    wb_wr_en = 1'b1; wb_thread = 2'd1; wb_addr = 5'd5; wb_data = 32'hDEAD;
    @(negedge clk);
    reset_n = 1'b1;
    check_sweep("sweep_wb");
    chk("fwd_after_init_wr",   o_rf_wr_en, 1);
    chk("fwd_after_init_thr",  o_rf_thread, 1);
    chk("fwd_after_init_addr", o_rf_addr, 5);
    chk("fwd_after_init_data", o_rf_data, 32'hDEAD);

    // x0 write dropped, normal write forwarded.
    @(negedge clk);
    wb_wr_en = 1'b1; wb_thread = 2'd1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    @(posedge clk); #2;
    chk("x0_drop", o_rf_wr_en, 0);
    @(negedge clk);
    wb_thread = 2'd2; wb_addr = 5'd3; wb_data = 32'h1234;
    @(posedge clk); #2;
    chk("run_fwd_wr",   o_rf_wr_en, 1);
    chk("run_fwd_thr",  o_rf_thread, 2);
    chk("run_fwd_addr", o_rf_addr, 3);
    chk("run_fwd_data", o_rf_data, 32'h1234);

    // Random run-time writeback traffic.
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      random_wb();
    end

    // Clear thread 3 with five writeback stalls to thread 0.
    @(negedge clk);
    drive_idle();
    clr_req = 1'b1; clr_thread = 2'd3;
    @(posedge clk); #2;
    chk("clr_accept_busy", o_busy, 1);
    stall_mask = '0;
    pick = 0;
    while (pick < 5) begin
      int s;
      s = $urandom_range(0, 31);
      if (!stall_mask[s]) begin
        stall_mask[s] = 1'b1;
        pick++;
      end
    end
    cyc = 0; fwd = 0; clrw = 0; clr_next = 0; got_ack = 1'b0;
    while (!got_ack && cyc < 100) begin
      @(negedge clk);
      if (cyc < 32 && stall_mask[cyc]) begin
        wb_wr_en = 1'b1; wb_thread = 2'd0;
        wb_addr = 5'($urandom_range(1, 31)); wb_data = $urandom;
      end else begin
        drive_idle();
      end
      @(posedge clk); #2;
      cyc++;
      if (o_rf_wr_en && o_rf_thread == 2'd0) fwd++;
      if (o_rf_wr_en && o_rf_thread == 2'd3) begin
        if (o_rf_addr != 5'(clr_next)) chk("clr_order", o_rf_addr, clr_next);
        clr_next++;
        clrw++;
      end
      if (o_clr_ack) got_ack = 1'b1;
    end
    chk("clr_latency", cyc, 37);
    chk("clr_fwd_count", fwd, 5);
    chk("clr_write_count", clrw, 32);
    @(negedge clk);
    drive_idle();
    @(posedge clk); #2;
    chk("clr_ack_once", o_clr_ack, 0);
    chk("clr_no_restart", o_busy, 0);
    @(negedge clk);
    clr_req = 1'b0;

    // Mixed random traffic with random clear requests.
    drop_next = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      random_wb();
      if (clr_req) begin
        if (drop_next) begin
          clr_req = 1'b0;
          drop_next = 1'b0;
        end else if (o_clr_ack) begin
          if ($urandom_range(0, 3) != 0) drop_next = 1'b1;
        end
      end else if ($urandom_range(0, 49) == 0) begin
        clr_req = 1'b1;
        clr_thread = TW'($urandom_range(0, NT - 1));
      end
    end
    if (clr_req) begin
      drive_idle();
      finish_clear("mix");
    end

    // Reset mid-sweep at entry 60, with a clear request pending across it.
    @(negedge clk);
    drive_idle();
    reset_n = 1'b0;
    clr_req = 1'b1; clr_thread = 2'd1;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (61) @(posedge clk);
    #1;
    chk("mid_entry60", {o_rf_thread, o_rf_addr}, 60);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_wr",   o_rf_wr_en, 0);
    chk("mid_rst_idx",  {o_rf_thread, o_rf_addr}, 0);
    chk("mid_rst_data", o_rf_data, 0);
    chk("mid_rst_busy", o_busy, 1);
    chk("mid_rst_done", o_init_done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    check_sweep("sweep_restart");
    chk("pending_clr_busy", o_busy, 1);
    finish_clear("pending");

    // Reset mid-clear: abandoned without ack, sweep restarts.
    @(negedge clk);
    clr_req = 1'b1; clr_thread = 2'd2;
    repeat (10) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("midclr_rst_ack",  o_clr_ack, 0);
    chk("midclr_rst_busy", o_busy, 1);
    @(negedge clk);
    clr_req = 1'b0;
    reset_n = 1'b1;
    check_sweep("sweep_after_clr");
    repeat (5) @(posedge clk);
    #2;
    chk("midclr_no_ack", o_clr_ack, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
